// File: rtl/count.sv
// ---------------------------------------------------------------------------
// count -- free-running modulo-N binary up-counter with terminal-count and
//          wrap flags.
//
// Counts every rising clock edge after reset is released. The count runs
// 0 .. MAX_VALUE and then returns to 0. There is no enable and no load.
//
// Parameters
//   COUNTER_WIDTH : width of cnt, 1..32
//   MAX_VALUE     : last count before returning to 0 (modulus = MAX_VALUE+1)
//   RESET_VALUE   : value held in cnt while reset is asserted
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   cnt      out  registered count value
//   tc       out  terminal count, high while cnt == MAX_VALUE
//   wrap     out  registered one-cycle pulse in the cycle after MAX_VALUE->0
//   cnt_gray out  registered Gray code of cnt (only with COUNT_GRAY_EN)
//
// Configuration macro
//   COUNT_GRAY_EN : when defined, adds the cnt_gray output and its register.
// ---------------------------------------------------------------------------
module count #(
    parameter int unsigned     COUNTER_WIDTH = 8,
    parameter longint unsigned MAX_VALUE     = (64'd1 << COUNTER_WIDTH) - 64'd1,
    parameter longint unsigned RESET_VALUE   = 64'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [COUNTER_WIDTH-1:0] cnt,
    output logic                     tc,
`ifdef COUNT_GRAY_EN
    output logic                     wrap,
    output logic [COUNTER_WIDTH-1:0] cnt_gray
`else
    output logic                     wrap
`endif
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if ((COUNTER_WIDTH < 1) || (COUNTER_WIDTH > 32)) begin : g_bad_width
        $fatal(1, "count: COUNTER_WIDTH must be in the range 1..32");
    end

    if (MAX_VALUE >= (64'd1 << COUNTER_WIDTH)) begin : g_bad_max
        $fatal(1, "count: MAX_VALUE must be less than 2**COUNTER_WIDTH");
    end

    localparam logic [COUNTER_WIDTH-1:0] MAX_C   = COUNTER_WIDTH'(MAX_VALUE);
    localparam logic [COUNTER_WIDTH-1:0] RESET_C = COUNTER_WIDTH'(RESET_VALUE);
    localparam logic [COUNTER_WIDTH-1:0] ONE_C   = COUNTER_WIDTH'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0] cnt_q,  cnt_d;
    logic                     wrap_q, wrap_d;
    logic                     at_max;

    assign at_max = (cnt_q == MAX_C);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q + ONE_C;
        wrap_d = at_max;
        // '>=' rather than '==' so that a RESET_VALUE above MAX_VALUE
        // falls straight back to 0 instead of counting on past the modulus.
        if (cnt_q >= MAX_C) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= RESET_C;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional Gray-coded copy of the count
    // -----------------------------------------------------------------------
`ifdef COUNT_GRAY_EN
    localparam logic [COUNTER_WIDTH-1:0] RESET_GRAY_C = RESET_C ^ (RESET_C >> 1);

    logic [COUNTER_WIDTH-1:0] gray_q, gray_d;

    // Encoded from the next binary value so the Gray register switches on
    // the same edge as cnt, without an extra pipeline stage.
    always_comb begin
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_q <= RESET_GRAY_C;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign cnt_gray = gray_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cnt  = cnt_q;
    assign tc   = at_max;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_count.sv
// ---------------------------------------------------------------------------
// tb_count -- directed, table-driven bench for the count module.
//
// Four 3-bit instances run in lockstep from one clock and reset:
//   A : MAX=7, RESET=0   (natural rollover)
//   B : MAX=5, RESET=0   (short modulus)
//   C : MAX=7, RESET=6   (non-zero reset value)
//   D : MAX=5, RESET=7   (reset value above the modulus)
// plus E with default parameters (8 bits, MAX=255).
// ---------------------------------------------------------------------------
module tb_count;

    logic       clk = 1'b0;
    logic       rst;

    logic [2:0] a_cnt, b_cnt, c_cnt, d_cnt;
    logic       a_tc,  b_tc,  c_tc,  d_tc;
    logic       a_wrap, b_wrap, c_wrap, d_wrap;
    logic [7:0] e_cnt;
    logic       e_tc, e_wrap;
`ifdef COUNT_GRAY_EN
    logic [2:0] a_gray, b_gray, c_gray, d_gray;
    logic [7:0] e_gray;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef COUNT_GRAY_EN
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(7), .RESET_VALUE(0)) u_a (
        .clk(clk), .rst(rst), .cnt(a_cnt), .tc(a_tc), .wrap(a_wrap), .cnt_gray(a_gray));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(5), .RESET_VALUE(0)) u_b (
        .clk(clk), .rst(rst), .cnt(b_cnt), .tc(b_tc), .wrap(b_wrap), .cnt_gray(b_gray));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(7), .RESET_VALUE(6)) u_c (
        .clk(clk), .rst(rst), .cnt(c_cnt), .tc(c_tc), .wrap(c_wrap), .cnt_gray(c_gray));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(5), .RESET_VALUE(7)) u_d (
        .clk(clk), .rst(rst), .cnt(d_cnt), .tc(d_tc), .wrap(d_wrap), .cnt_gray(d_gray));
    count u_e (
        .clk(clk), .rst(rst), .cnt(e_cnt), .tc(e_tc), .wrap(e_wrap), .cnt_gray(e_gray));
`else
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(7), .RESET_VALUE(0)) u_a (
        .clk(clk), .rst(rst), .cnt(a_cnt), .tc(a_tc), .wrap(a_wrap));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(5), .RESET_VALUE(0)) u_b (
        .clk(clk), .rst(rst), .cnt(b_cnt), .tc(b_tc), .wrap(b_wrap));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(7), .RESET_VALUE(6)) u_c (
        .clk(clk), .rst(rst), .cnt(c_cnt), .tc(c_tc), .wrap(c_wrap));
    count #(.COUNTER_WIDTH(3), .MAX_VALUE(5), .RESET_VALUE(7)) u_d (
        .clk(clk), .rst(rst), .cnt(d_cnt), .tc(d_tc), .wrap(d_wrap));
    count u_e (
        .clk(clk), .rst(rst), .cnt(e_cnt), .tc(e_tc), .wrap(e_wrap));
`endif

    // Expected {cnt, tc, wrap} for one 3-bit instance.
    typedef struct packed {
        logic [2:0] cnt;
        logic       tc;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic rst;
        exp_t a;
        exp_t b;
        exp_t c;
        exp_t d;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_vec(input int i, input exp_t a, input exp_t b,
                           input exp_t c, input exp_t d);
        chk("a_cnt", i, 32'(a_cnt), 32'(a.cnt));
        chk("a_tc", i, 32'(a_tc), 32'(a.tc));
        chk("a_wrap", i, 32'(a_wrap), 32'(a.wrap));
        chk("b_cnt", i, 32'(b_cnt), 32'(b.cnt));
        chk("b_tc", i, 32'(b_tc), 32'(b.tc));
        chk("b_wrap", i, 32'(b_wrap), 32'(b.wrap));
        chk("c_cnt", i, 32'(c_cnt), 32'(c.cnt));
        chk("c_tc", i, 32'(c_tc), 32'(c.tc));
        chk("c_wrap", i, 32'(c_wrap), 32'(c.wrap));
        chk("d_cnt", i, 32'(d_cnt), 32'(d.cnt));
        chk("d_tc", i, 32'(d_tc), 32'(d.tc));
        chk("d_wrap", i, 32'(d_wrap), 32'(d.wrap));
    endtask

`ifdef COUNT_GRAY_EN
    // Reference Gray sequence for a 3-bit count, indexed by binary value.
    logic [2:0] gray_tab [8];
    logic [2:0] prev_gray;
`endif

    initial begin
        // rst, A {cnt,tc,wrap}, B, C, D  (each checked after one rising edge)
        vecs[0]  = '{1'b0, 5'b000_0_0, 5'b000_0_0, 5'b110_0_0, 5'b111_0_0};
        vecs[1]  = '{1'b1, 5'b001_0_0, 5'b001_0_0, 5'b111_1_0, 5'b000_0_0};
        vecs[2]  = '{1'b1, 5'b010_0_0, 5'b010_0_0, 5'b000_0_1, 5'b001_0_0};
        vecs[3]  = '{1'b1, 5'b011_0_0, 5'b011_0_0, 5'b001_0_0, 5'b010_0_0};
        vecs[4]  = '{1'b1, 5'b100_0_0, 5'b100_0_0, 5'b010_0_0, 5'b011_0_0};
        vecs[5]  = '{1'b1, 5'b101_0_0, 5'b101_1_0, 5'b011_0_0, 5'b100_0_0};
        vecs[6]  = '{1'b1, 5'b110_0_0, 5'b000_0_1, 5'b100_0_0, 5'b101_1_0};
        vecs[7]  = '{1'b1, 5'b111_1_0, 5'b001_0_0, 5'b101_0_0, 5'b000_0_1};
        vecs[8]  = '{1'b1, 5'b000_0_1, 5'b010_0_0, 5'b110_0_0, 5'b001_0_0};
        vecs[9]  = '{1'b1, 5'b001_0_0, 5'b011_0_0, 5'b111_1_0, 5'b010_0_0};
        vecs[10] = '{1'b1, 5'b010_0_0, 5'b100_0_0, 5'b000_0_1, 5'b011_0_0};
        vecs[11] = '{1'b1, 5'b011_0_0, 5'b101_1_0, 5'b001_0_0, 5'b100_0_0};

`ifdef COUNT_GRAY_EN
        gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
`endif

        // Asynchronous reset with no clock edge yet.
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk_vec(-1, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d);
        chk("e_cnt_rst", -1, 32'(e_cnt), 32'd0);
        chk("e_tc_rst", -1, 32'(e_tc), 32'd0);
`ifdef COUNT_GRAY_EN
        chk("c_gray_rst", -1, 32'(c_gray), 32'(3'b101));
        chk("d_gray_rst", -1, 32'(d_gray), 32'(3'b100));
`endif

        // Table-driven lockstep run.
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            @(posedge clk);
            #1;
            chk_vec(i, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
`ifdef COUNT_GRAY_EN
            chk("a_gray", i, 32'(a_gray), 32'(gray_tab[vecs[i].a.cnt]));
            chk("b_gray", i, 32'(b_gray), 32'(gray_tab[vecs[i].b.cnt]));
            if (i > 0) begin
                chk("a_gray_hd", i, 32'($countones(a_gray ^ prev_gray)), 32'd1);
            end
            prev_gray = a_gray;
`endif
        end

        // Asynchronous reset mid-cycle at A=4: clears before the next edge.
        @(posedge clk);
        #1;
        chk("seq1_a_cnt4", 0, 32'(a_cnt), 32'd4);
        #2 rst = 1'b0;
        #1;
        chk("seq1_a_async", 0, 32'(a_cnt), 32'd0);
        chk("seq1_c_async", 0, 32'(c_cnt), 32'd6);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("seq1_a_hold", k, 32'(a_cnt), 32'd0);
            chk("seq1_a_wrap", k, 32'(a_wrap), 32'd0);
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("seq1_a_first", 0, 32'(a_cnt), 32'd1);
        chk("seq1_c_first", 0, 32'(c_cnt), 32'd7);
        chk("seq1_c_tc", 0, 32'(c_tc), 32'd1);

        // Reset taken while A sits at MAX must not produce a wrap pulse.
        repeat (6) @(posedge clk);
        #1;
        chk("seq2_a_max", 0, 32'(a_cnt), 32'd7);
        chk("seq2_a_tc", 0, 32'(a_tc), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("seq2_a_cnt", 0, 32'(a_cnt), 32'd0);
        chk("seq2_a_tc0", 0, 32'(a_tc), 32'd0);
        chk("seq2_a_wrap", 0, 32'(a_wrap), 32'd0);
        @(posedge clk);
        #1;
        chk("seq2_a_wrap", 1, 32'(a_wrap), 32'd0);
        chk("seq2_e_cnt", 0, 32'(e_cnt), 32'd0);

        // Default-parameter instance: full 8-bit rollover.
        #2 rst = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("seq3_e_cnt", 0, 32'(e_cnt), 32'd255);
        chk("seq3_e_tc", 0, 32'(e_tc), 32'd1);
        chk("seq3_e_wrap", 0, 32'(e_wrap), 32'd0);
        @(posedge clk);
        #1;
        chk("seq3_e_cnt", 1, 32'(e_cnt), 32'd0);
        chk("seq3_e_tc", 1, 32'(e_tc), 32'd0);
        chk("seq3_e_wrap", 1, 32'(e_wrap), 32'd1);
        @(posedge clk);
        #1;
        chk("seq3_e_cnt", 2, 32'(e_cnt), 32'd1);
        chk("seq3_e_wrap", 2, 32'(e_wrap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
